dl_reg_wr_arb: RTL
==================

// Module: dl_reg_wr_arb
// PURPOSE
//   Round-robin write arbiter in front of a shared enabled register.
//   - NUM_REQ requesters compete to load one NUM_BITS register; one write per cycle.
//   - Holds the register value and reports which requester wrote it last.
//   - Used wherever pipeline stages or CSR writers share a single state register.
// PARAMETERS
//   NUM_BITS  8   width of the shared register and of each request payload
//   NUM_REQ   4   number of requesters, >=2
//   ID_BITS   $clog2(NUM_REQ)   width of requester index (derived, not overridden)
// PORTS
//   clk        in   1                   rising-edge clock
//   rst        in   1                   synchronous, active-high reset
//   req_val    in   NUM_REQ             per-requester write valid
//   req_data   in   NUM_REQ*NUM_BITS    payloads; requester i at [i*NUM_BITS +: NUM_BITS]
//   req_rdy    out  NUM_REQ             one-hot grant, combinational; 0 if no req_val
//   req_lock   in   NUM_REQ             lock request (only with DL_REG_WR_ARB_LOCK_EN)
//   q          out  NUM_BITS            shared register value
//   q_val      out  1                   sticky: 1 once any write has occurred since reset
//   wr_pulse   out  1                   1 for exactly the cycle after a write edge
//   last_id    out  ID_BITS             index of requester that performed the last write
// BEHAVIOUR
//   - Reset (rst=1 at posedge) values:
//     - q=0, q_val=0, wr_pulse=0, last_id=0, ptr=0, locked=0.
//     - req_rdy is still combinational but forced 0 while rst=1.
//   - Transfer: req_val[i] & req_rdy[i].
//     - Next edge: q<=payload i, last_id<=i, q_val<=1, wr_pulse<=1.
//     - Latency from transfer cycle to q visible: 1 cycle.
//   - No transfer: q, last_id, q_val hold; wr_pulse<=0.
//   - Arbitration, unlocked:
//     - Grant the first asserted req_val scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
//     - After granting i: ptr <= (i==NUM_REQ-1) ? 0 : i+1.
//     - No req_val: ptr holds.
//   - Grant depends only on req_val and state; req_rdy never depends on req_data.
//   - A requester may drop req_val without a transfer; no state change results.
//   - Single requester continuously valid: granted every cycle, no bubbles.
// CONFIGURATION
//   Macro DL_REG_WR_ARB_LOCK_EN:
//   - Defined: req_lock port exists; FSM states UNLOCKED / LOCKED(owner).
//     - UNLOCKED->LOCKED: transfer by i with req_lock[i]=1; owner<=i.
//     - In LOCKED:
//       - req_rdy = one-hot(owner) when req_val[owner]=1, else 0.
//       - All other requesters are held off.
//     - LOCKED->UNLOCKED on either event:
//       - owner transfers with req_lock=0 (write takes effect);
//       - owner has req_val=0 for a cycle.
//     - On release: ptr <= owner+1 mod NUM_REQ.
//     - rst in LOCKED: immediate return to UNLOCKED, ptr=0.
//   - Undefined: no req_lock port; pure per-cycle round robin as above.
// STRUCTURE
//   - Shared package dl_arb_pkg:
//     - localparam ID width function (clog2 wrapper).
//     - FSM state encoding (ARB_UNLOCKED=1'b0, ARB_LOCKED=1'b1).
//   - Sub-module dl_rr_pick #(NUM_REQ):
//     - Combinational rotate-priority picker.
//     - Inputs: req vector, ptr. Outputs: one-hot gnt, gnt_id, any.
//   - Top level holds ptr, lock FSM, and storage for q / q_val / last_id / wr_pulse.
// TESTING (NUM_BITS=8, NUM_REQ=4)
//   1. Reset, then hold rst=0 with no req
//      -> q=0x00, q_val=0, wr_pulse=0, last_id=0, req_rdy=0000.
//   2. req_val=0001, data0=0xA5
//      -> req_rdy=0001; next cycle q=0xA5, q_val=1, wr_pulse=1, last_id=0.
//   3. req_val=1111 held 8 cycles, data i=0x10+i
//      -> grants 0,1,2,3,0,1,2,3 (starting ptr=0); q trails grants by 1 cycle.
//   4. ptr=3, req_val=0101
//      -> grant 0 (wrap); then grant 2; then grant 0.
//   5. LOCK_EN: req 1 transfers with lock=1, req_val=1111 for 3 cycles
//      -> rdy=0010 each cycle; req1 lock=0 transfer -> next grant 2.
//   6. rst asserted while LOCKED with transfers in flight
//      -> next cycle q=0, q_val=0, unlocked, ptr=0; req_val=1111 -> grant 0.

Source files
------------

// File: rtl/dl_arb_pkg.sv
// Shared definitions for the register write arbiter: requester-index width helper
// and lock FSM state encoding.
package dl_arb_pkg;

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dl_rr_pick.sv
// Combinational rotate-priority picker: grants the first set request found
// scanning ptr, ptr+1, ... with wrap-around.
module dl_rr_pick
    import dl_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_BITS = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_BITS-1:0] ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_BITS-1:0] gnt_id_o,
    output logic               any_o
);

    int unsigned idx;

    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = ID_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/dl_reg_wr_arb.sv
// Round-robin write arbiter in front of a shared register.
// Optional requester lock feature enabled by defining DL_REG_WR_ARB_LOCK_EN.
module dl_reg_wr_arb
    import dl_arb_pkg::*;
#(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned NUM_REQ  = 4,
    localparam int unsigned ID_BITS = id_width(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_val,
    input  logic [NUM_REQ*NUM_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_rdy,
`ifdef DL_REG_WR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          req_lock,
`endif
    output logic [NUM_BITS-1:0]         q,
    output logic                        q_val,
    output logic                        wr_pulse,
    output logic [ID_BITS-1:0]          last_id
);

    function automatic logic [ID_BITS-1:0] wrap_inc(input logic [ID_BITS-1:0] id);
        return (id == ID_BITS'(NUM_REQ - 1)) ? '0 : id + ID_BITS'(1);
    endfunction

    logic [NUM_BITS-1:0] q_q, q_d;
    logic                q_val_q, q_val_d;
    logic                wr_pulse_q, wr_pulse_d;
    logic [ID_BITS-1:0]  last_id_q, last_id_d;
    logic [ID_BITS-1:0]  ptr_q, ptr_d;

    logic [NUM_REQ-1:0]  pick_req;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ID_BITS-1:0]  pick_id;
    logic                pick_any;
    logic                xfer;
    logic [NUM_BITS-1:0] wr_data;

`ifdef DL_REG_WR_ARB_LOCK_EN
    arb_state_e          state_q, state_d;
    logic [ID_BITS-1:0]  owner_q, owner_d;
`endif

    // While locked, only the owner is presented to the picker.
    always_comb begin
        pick_req = req_val;
`ifdef DL_REG_WR_ARB_LOCK_EN
        if (state_q == ARB_LOCKED) begin
            pick_req = req_val & (NUM_REQ'(1) << owner_q);
        end
`endif
    end

    dl_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_BITS (ID_BITS)
    ) u_pick (
        .req_i    (pick_req),
        .ptr_i    (ptr_q),
        .gnt_o    (pick_gnt),
        .gnt_id_o (pick_id),
        .any_o    (pick_any)
    );

    assign req_rdy = rst ? '0 : pick_gnt;
    assign xfer    = pick_any & ~rst;

    always_comb begin
        wr_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                wr_data = req_data[i*NUM_BITS +: NUM_BITS];
            end
        end
    end

    always_comb begin
        q_d        = q_q;
        q_val_d    = q_val_q;
        last_id_d  = last_id_q;
        ptr_d      = ptr_q;
        wr_pulse_d = xfer;
        if (xfer) begin
            q_d       = wr_data;
            q_val_d   = 1'b1;
            last_id_d = pick_id;
            ptr_d     = wrap_inc(pick_id);
        end
`ifdef DL_REG_WR_ARB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ARB_UNLOCKED: begin
                if (xfer && req_lock[pick_id]) begin
                    state_d = ARB_LOCKED;
                    owner_d = pick_id;
                end
            end
            ARB_LOCKED: begin
                if (!req_val[owner_q] || !req_lock[owner_q]) begin
                    state_d = ARB_UNLOCKED;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: state_d = ARB_UNLOCKED;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q        <= '0;
            q_val_q    <= 1'b0;
            wr_pulse_q <= 1'b0;
            last_id_q  <= '0;
            ptr_q      <= '0;
`ifdef DL_REG_WR_ARB_LOCK_EN
            state_q    <= ARB_UNLOCKED;
            owner_q    <= '0;
`endif
        end else begin
            q_q        <= q_d;
            q_val_q    <= q_val_d;
            wr_pulse_q <= wr_pulse_d;
            last_id_q  <= last_id_d;
            ptr_q      <= ptr_d;
`ifdef DL_REG_WR_ARB_LOCK_EN
            state_q    <= state_d;
            owner_q    <= owner_d;
`endif
        end
    end

    assign q        = q_q;
    assign q_val    = q_val_q;
    assign wr_pulse = wr_pulse_q;
    assign last_id  = last_id_q;

endmodule
